dpram_port_arbiter: RTL and testbench

- Shares one port of the 256x16 true-dual-port RAM between two requesters: REQ0, the host register/SPI side, and REQ1, the sensor logger side.
- Arbitrates between them in round-robin order and sequences each access over a fixed 3-cycle window: issue, RAM sample, capture.
- Drives a single-cycle RAM write strobe and returns read data with a one-cycle acknowledge.
- Sits between the requesters and the RAM port's CLK/WEN/ADDR/DATA_IN/DATA_OUT pins. That RAM port is clocked by CLK.

---
 rtl/dpram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one port of a 256x16 true-dual-port RAM between
// the host/SPI requester (0) and the sensor logger requester (1).
// Each access takes a fixed three-state window: grant/issue, RAM sample, capture.
// Optional feature macro: DPRAM_ARB_WPROT_EN (blocks requester-1 writes at or
// above WPROT_BASE; the blocked access is performed as a read and flagged on ERR_1).
module dpram_port_arbiter #(
  parameter int                 ADDR_W     = 8,
  parameter int                 DATA_W     = 16,
  parameter int                 FIXED_PRIO = 0,
  parameter logic [ADDR_W-1:0]  WPROT_BASE = 8'hC0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_0,
  input  logic              REQ_1,
  input  logic              WEN_0,
  input  logic              WEN_1,
  input  logic [ADDR_W-1:0] ADDR_0,
  input  logic [ADDR_W-1:0] ADDR_1,
  input  logic [DATA_W-1:0] WDATA_0,
  input  logic [DATA_W-1:0] WDATA_1,
  output logic              ACK_0,
  output logic              ACK_1,
  output logic [DATA_W-1:0] RDATA_0,
  output logic [DATA_W-1:0] RDATA_1,
  output logic              ERR_1,
  output logic              BUSY,
  output logic              RAM_WEN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DIN,
  input  logic [DATA_W-1:0] RAM_DOUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t state;
  logic   gnt;          // requester owning the current access
  logic   last_gnt;     // requester served most recently
  logic   is_write;     // original request was a write (RDATA left untouched)
  logic   blocked_r;    // write was suppressed by write protection

  logic              elig_0;
  logic              elig_1;
  logic              any_elig;
  logic              pick;
  logic              sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              blocked;

  // Grant selection and request mux; a requester whose ACK is high sits out one cycle.
  always_comb begin
    elig_0   = REQ_0 & ~ACK_0;
    elig_1   = REQ_1 & ~ACK_1;
    any_elig = elig_0 | elig_1;
    pick     = 1'b0;
    if (elig_0 && elig_1) begin
      if (FIXED_PRIO != 0) begin
        pick = 1'b0;
      end else begin
        pick = ~last_gnt;
      end
    end else if (elig_1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    if (pick) begin
      sel_wen  = WEN_1;
      sel_addr = ADDR_1;
      sel_din  = WDATA_1;
    end else begin
      sel_wen  = WEN_0;
      sel_addr = ADDR_0;
      sel_din  = WDATA_0;
    end
`ifdef DPRAM_ARB_WPROT_EN
    blocked = pick & WEN_1 & (ADDR_1 >= WPROT_BASE);
`else
    blocked = 1'b0;
`endif
  end

`ifndef DPRAM_ARB_WPROT_EN
  // Base address only matters when write protection is built in.
  logic unused_wprot;
  assign unused_wprot = ^WPROT_BASE;
`endif

  // Access sequencer: grant in IDLE, one-cycle write strobe in ISSUE, capture and ACK out of SAMPLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      is_write  <= 1'b0;
      blocked_r <= 1'b0;
      ACK_0     <= 1'b0;
      ACK_1     <= 1'b0;
      ERR_1     <= 1'b0;
      BUSY      <= 1'b0;
      RAM_WEN   <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_DIN   <= '0;
      RDATA_0   <= '0;
      RDATA_1   <= '0;
    end else begin
      ACK_0 <= 1'b0;
      ACK_1 <= 1'b0;
      ERR_1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            gnt       <= pick;
            last_gnt  <= pick;
            RAM_ADDR  <= sel_addr;
            RAM_DIN   <= sel_din;
            RAM_WEN   <= sel_wen & ~blocked;
            is_write  <= sel_wen;
            blocked_r <= blocked;
            BUSY      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          RAM_WEN <= 1'b0;
          state   <= SAMPLE;
        end
        SAMPLE: begin
          if (gnt) begin
            ACK_1 <= 1'b1;
            ERR_1 <= blocked_r;
            if (!is_write) begin
              RDATA_1 <= RAM_DOUT;
            end
          end else begin
            ACK_0 <= 1'b1;
            if (!is_write) begin
              RDATA_0 <= RAM_DOUT;
            end
          end
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          RAM_WEN <= 1'b0;
          BUSY    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed testbench for dpram_port_arbiter. Two instances share the request
// inputs: a round-robin one (main) and a FIXED_PRIO = 1 one, each with its own
// behavioural registered-read RAM.
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wen0, wen1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic        ack0, ack1, err1, busy, ram_wen;
  logic [15:0] rdata0, rdata1, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  logic        fp_ack0, fp_ack1, fp_err1, fp_busy, fp_ram_wen;
  logic [15:0] fp_rdata0, fp_rdata1, fp_ram_din, fp_ram_dout;
  logic [7:0]  fp_ram_addr;

  logic [15:0] mem    [0:255];
  logic [15:0] mem_fp [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(0), .WPROT_BASE(8'hC0)) dut (
    .CLK(clk), .RST(rst), .REQ_0(req0), .REQ_1(req1), .WEN_0(wen0), .WEN_1(wen1),
    .ADDR_0(addr0), .ADDR_1(addr1), .WDATA_0(wdata0), .WDATA_1(wdata1),
    .ACK_0(ack0), .ACK_1(ack1), .RDATA_0(rdata0), .RDATA_1(rdata1), .ERR_1(err1),
    .BUSY(busy), .RAM_WEN(ram_wen), .RAM_ADDR(ram_addr), .RAM_DIN(ram_din), .RAM_DOUT(ram_dout));

  dpram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1), .WPROT_BASE(8'hC0)) dut_fp (
    .CLK(clk), .RST(rst), .REQ_0(req0), .REQ_1(req1), .WEN_0(wen0), .WEN_1(wen1),
    .ADDR_0(addr0), .ADDR_1(addr1), .WDATA_0(wdata0), .WDATA_1(wdata1),
    .ACK_0(fp_ack0), .ACK_1(fp_ack1), .RDATA_0(fp_rdata0), .RDATA_1(fp_rdata1), .ERR_1(fp_err1),
    .BUSY(fp_busy), .RAM_WEN(fp_ram_wen), .RAM_ADDR(fp_ram_addr), .RAM_DIN(fp_ram_din),
    .RAM_DOUT(fp_ram_dout));

  // Registered-read RAM models (read-before-write).
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (fp_ram_wen) mem_fp[fp_ram_addr] <= fp_ram_din;
    fp_ram_dout <= mem_fp[fp_ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One complete access on the main instance; returns observations per cycle.
  task automatic run_access(input bit p, input bit w, input logic [7:0] a, input logic [15:0] d,
                            output bit wen_c1, output logic [7:0] a_obs, output bit wen_c2,
                            output bit ack_early, output bit ack_on, output logic [15:0] rd,
                            output bit er, output bit ack_after);
    if (p) begin req1 = 1'b1; wen1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; wen0 = w; addr0 = a; wdata0 = d; end
    tick();
    wen_c1 = ram_wen; a_obs = ram_addr; ack_early = p ? ack1 : ack0;
    tick();
    wen_c2 = ram_wen; ack_early = ack_early | (p ? ack1 : ack0);
    tick();
    ack_on = p ? ack1 : ack0; rd = p ? rdata1 : rdata0; er = err1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    ack_after = p ? ack1 : ack0;
  endtask

  bit          w1, w2, ae, ao, aa, er;
  logic [7:0]  ao_addr;
  logic [15:0] rd, prev;

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    checks++; if ({ack0, ack1, err1, busy, ram_wen} !== 5'b00000) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {ack0, ack1, err1, busy, ram_wen}); end
    checks++; if ({ram_addr, ram_din} !== 24'h000000) begin errors++; $display("FAIL reset_ram_bus: got %h expected 000000", {ram_addr, ram_din}); end
    checks++; if ({rdata0, rdata1} !== 32'h00000000) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", {rdata0, rdata1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    run_access(1'b0, 1'b1, 8'h10, 16'hA5A5, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if ({w1, w2} !== 2'b10) begin errors++; $display("FAIL wr_wen_pulse: got %b expected 10", {w1, w2}); end
    checks++; if (ao_addr !== 8'h10) begin errors++; $display("FAIL wr_ram_addr: got %h expected 10", ao_addr); end
    checks++; if ({ae, ao, aa} !== 3'b010) begin errors++; $display("FAIL wr_ack_timing: got %b expected 010", {ae, ao, aa}); end
    run_access(1'b0, 1'b0, 8'h10, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if (w1 !== 1'b0) begin errors++; $display("FAIL rd_no_wen: got %b expected 0", w1); end
    checks++; if ({ao, rd} !== {1'b1, 16'hA5A5}) begin errors++; $display("FAIL rd_data: got %h expected 1a5a5", {ao, rd}); end
  endtask

  task automatic test_round_robin();
    logic [13:1] m0, m1;
    do_reset();
    wen0 = 1'b0; wen1 = 1'b0; addr0 = 8'h10; addr1 = 8'h20;
    req0 = 1'b1; req1 = 1'b1;
    m0 = '0; m1 = '0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      m0[i] = ack0; m1[i] = ack1;
    end
    checks++; if (m0 !== 13'b0000100000100) begin errors++; $display("FAIL rr_ack0: got %b expected 0000100000100", m0); end
    checks++; if (m1 !== 13'b0100000100000) begin errors++; $display("FAIL rr_ack1: got %b expected 0100000100000", m1); end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    run_access(1'b0, 1'b0, 8'h10, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    wen0 = 1'b0; wen1 = 1'b0; addr0 = 8'h10; addr1 = 8'h20;
    req0 = 1'b1; req1 = 1'b1;
    tick(); tick(); tick();
    checks++; if ({ack0, ack1} !== 2'b01) begin errors++; $display("FAIL rr_tie_after_0: got %b expected 01", {ack0, ack1}); end
    checks++; if ({fp_ack0, fp_ack1} !== 2'b10) begin errors++; $display("FAIL fp_tie_after_0: got %b expected 10", {fp_ack0, fp_ack1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    checks++; if ({busy, fp_busy} !== 2'b00) begin errors++; $display("FAIL tie_idle_after: got %b expected 00", {busy, fp_busy}); end
  endtask

  task automatic test_rdata_hold();
    run_access(1'b1, 1'b1, 8'h20, 16'h1234, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if ({w1, ao, er} !== 3'b110) begin errors++; $display("FAIL r1_write: got %b expected 110", {w1, ao, er}); end
    run_access(1'b0, 1'b0, 8'h20, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL r0_read_20: got %h expected 1234", rd); end
    run_access(1'b1, 1'b0, 8'h20, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL r1_read_20: got %h expected 1234", rd); end
    run_access(1'b1, 1'b1, 8'h40, 16'h5555, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if ({ao, rd} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL r1_write_keeps_rdata: got %h expected 11234", {ao, rd}); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    req0 = 1'b1; wen0 = 1'b1; addr0 = 8'h30; wdata0 = 16'hBEEF;
    tick();
    checks++; if ({ram_wen, busy} !== 2'b11) begin errors++; $display("FAIL abort_issue: got %b expected 11", {ram_wen, busy}); end
    rst = 1'b1; req0 = 1'b0;
    tick();
    checks++; if ({ram_wen, busy} !== 2'b00) begin errors++; $display("FAIL abort_cleared: got %b expected 00", {ram_wen, busy}); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | ack0 | ack1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b expected 0", seen); end
    wen0 = 1'b0; wen1 = 1'b0; addr0 = 8'h10; addr1 = 8'h20;
    req0 = 1'b1; req1 = 1'b1;
    tick(); tick(); tick();
    checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL abort_last_gnt: got %b expected 10", {ack0, ack1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wprot();
    run_access(1'b0, 1'b1, 8'hC0, 16'h1111, w1, ao_addr, w2, ae, ao, rd, er, aa);
    prev = rdata1;
    run_access(1'b1, 1'b1, 8'hC0, 16'hDEAD, w1, ao_addr, w2, ae, ao, rd, er, aa);
`ifdef DPRAM_ARB_WPROT_EN
    checks++; if ({w1, ao, er} !== 3'b011) begin errors++; $display("FAIL wprot_block: got %b expected 011", {w1, ao, er}); end
    checks++; if (rd !== prev) begin errors++; $display("FAIL wprot_rdata_hold: got %h expected %h", rd, prev); end
    run_access(1'b0, 1'b0, 8'hC0, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL wprot_old_value: got %h expected 1111", rd); end
`else
    checks++; if ({w1, ao, er} !== 3'b110) begin errors++; $display("FAIL noprot_write: got %b expected 110", {w1, ao, er}); end
    run_access(1'b0, 1'b0, 8'hC0, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if (rd !== 16'hDEAD) begin errors++; $display("FAIL noprot_value: got %h expected dead", rd); end
`endif
    run_access(1'b1, 1'b1, 8'hBF, 16'h7777, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if ({w1, ao, er} !== 3'b110) begin errors++; $display("FAIL bf_write: got %b expected 110", {w1, ao, er}); end
    run_access(1'b0, 1'b0, 8'hBF, 16'h0000, w1, ao_addr, w2, ae, ao, rd, er, aa);
    checks++; if (rd !== 16'h7777) begin errors++; $display("FAIL bf_value: got %h expected 7777", rd); end
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; wen0 = 1'b0; addr0 = 8'h10;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_first: got %b expected 1", busy); end
    tick(); tick();
    checks++; if ({ack0, rdata0} !== {1'b1, 16'hA5A5}) begin errors++; $display("FAIL b2b_ack_first: got %h expected 1a5a5", {ack0, rdata0}); end
    tick();
    checks++; if ({busy, ack0} !== 2'b00) begin errors++; $display("FAIL b2b_gap: got %b expected 00", {busy, ack0}); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_regrant: got %b expected 1", busy); end
    tick(); tick();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL b2b_ack_second: got %b expected 1", ack0); end
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0000; wdata1 = 16'h0000;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_write_read();
    test_rdata_hold();
    test_reset_abort();
    test_wprot();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
